// File: rtl/levitate_pkg.sv
// rtl/levitate_pkg.sv - frame constants, parser states and grid helpers for the levitation command parser
package levitate_pkg;

    localparam logic [7:0] SOF_BYTE  = 8'hFF;
    localparam logic [7:0] EOF_BYTE  = 8'h3C;

    localparam logic [7:0] CMD_LEFT  = 8'h41;
    localparam logic [7:0] CMD_RIGHT = 8'h44;
    localparam logic [7:0] CMD_FWD   = 8'h57;
    localparam logic [7:0] CMD_BACK  = 8'h53;

    localparam int GRID_MAX = 4;
    localparam int POS_W    = 3;
    localparam int DELAY_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        PHASE,
        EOF
    } parser_state_t;

    // One grid step in either direction, clamped to [0, max_pos].
    function automatic logic [POS_W-1:0] step_pos(
        input logic [POS_W-1:0] pos,
        input logic             up,
        input logic [POS_W-1:0] max_pos
    );
        logic [POS_W-1:0] res;
        if (up) begin
            res = (pos >= max_pos) ? max_pos : pos + 1'b1;
        end else begin
            res = (pos == '0) ? '0 : pos - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// rtl/cmd_timeout_cnt.sv - idle-cycle counter that pulses expired after TIMEOUT_CYC-1 enabled cycles
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Holds at the terminal value so a stalled owner never sees the count wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable & ~clear & (cnt == CNT_LAST);

endmodule

// File: rtl/levitate_cmd_parser.sv
// rtl/levitate_cmd_parser.sv - validates SOF/cmd/phase/EOF frames and commits grid position and phase delay
module levitate_cmd_parser
    import levitate_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_CYC = 2_500_000,
    parameter int MAX_POS     = GRID_MAX,
    parameter int INIT_POS    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_rdy,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic [DELAY_W-1:0] delay,
    output logic               cfg_valid,
    output logic               frame_err,
    output logic               busy_n
);

    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

    if ((CLK_HZ <= 0) || (TIMEOUT_CYC < 2) || (MAX_POS > 7) || (INIT_POS > MAX_POS)) begin : g_param_check
        $error("levitate_cmd_parser: illegal parameter set");
    end

    parser_state_t state, state_nxt;

    logic       rx_rdy_q;
    logic       byte_stb;
    logic       tmo_expired;
    logic [7:0] cmd_q;
    logic [7:0] ph_q;
    logic       capture_cmd;
    logic       capture_ph;
    logic       do_commit;
    logic       do_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_rdy_q <= 1'b0;
        end else begin
            rx_rdy_q <= rx_rdy;
        end
    end

    assign byte_stb = rx_rdy & ~rx_rdy_q;

    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (byte_stb | (state == IDLE)),
        .enable  (state != IDLE),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tmo_expired is already masked by byte_stb, so a byte arriving on the
    // terminal count always takes the byte path.
    always_comb begin
        state_nxt   = state;
        capture_cmd = 1'b0;
        capture_ph  = 1'b0;
        do_commit   = 1'b0;
        do_err      = 1'b0;
        case (state)
            IDLE: begin
                if (byte_stb && (rx_data == SOF_BYTE)) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                if (byte_stb) begin
                    capture_cmd = 1'b1;
                    state_nxt   = PHASE;
                end else if (tmo_expired) begin
                    do_err    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PHASE: begin
                if (byte_stb) begin
                    capture_ph = 1'b1;
                    state_nxt  = EOF;
                end else if (tmo_expired) begin
                    do_err    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EOF: begin
                if (byte_stb) begin
                    if (rx_data == EOF_BYTE) begin
                        do_commit = 1'b1;
                        state_nxt = IDLE;
                    end else if (rx_data == SOF_BYTE) begin
                        do_err    = 1'b1;
                        state_nxt = CMD;
                    end else begin
                        do_err    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_expired) begin
                    do_err    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
            ph_q  <= '0;
        end else begin
            if (capture_cmd) begin
                cmd_q <= rx_data;
            end
            if (capture_ph) begin
                ph_q <= rx_data;
            end
        end
    end

    // Position and delay change together, only on a fully validated frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x     <= POS_INIT;
            pos_y     <= POS_INIT;
            delay     <= '0;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cfg_valid <= do_commit;
            frame_err <= do_err;
            if (do_commit) begin
                delay <= {ph_q, 2'b00};
                case (cmd_q)
                    CMD_LEFT:  pos_x <= step_pos(pos_x, 1'b0, POS_MAX);
                    CMD_RIGHT: pos_x <= step_pos(pos_x, 1'b1, POS_MAX);
                    CMD_FWD:   pos_y <= step_pos(pos_y, 1'b1, POS_MAX);
                    CMD_BACK:  pos_y <= step_pos(pos_y, 1'b0, POS_MAX);
                    default: ;
                endcase
            end
        end
    end

    assign busy_n = (state == IDLE);

endmodule
